// File: rtl/wb_stage_nway_pkg.sv
// rtl/wb_stage_nway_pkg.sv - shared field widths and trace record layout for the writeback stage
package wb_stage_nway_pkg;
  localparam int REG_W = 5;
  localparam int PC_W  = 32;
  localparam logic [3:0] WEN_ON = 4'hF;

  // Trace record is {pc, wnum, wdata}, pc in the top bits.
  function automatic int trace_rec_w(input int xlen);
    return PC_W + REG_W + xlen;
  endfunction
endpackage

// File: rtl/wb_trace_fifo.sv
// rtl/wb_trace_fifo.sv - multi-push, single-pop circular trace queue; pops whenever non-empty
module wb_trace_fifo #(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int W     = 69
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LANES-1:0]             i_push,
  input  logic [W*LANES-1:0]           i_push_data,
  output logic                         o_pop,
  output logic [W-1:0]                 o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] MASK = AW'(DEPTH - 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_off [LANES];
  logic [CW-1:0] w_n_push;

  // Pushing lanes are packed densely: each lands after the pushing lanes below it.
  always_comb begin
    w_n_push = '0;
    for (int i = 0; i < LANES; i++) begin
      w_off[i] = w_n_push;
      w_n_push = w_n_push + CW'(i_push[i]);
    end
  end

  assign o_pop   = (r_count != '0);
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (i_push[i]) r_mem[(r_wptr + AW'(w_off[i])) & MASK] <= i_push_data[i*W +: W];
      end
      r_wptr  <= (r_wptr + AW'(w_n_push)) & MASK;
      if (o_pop) r_rptr <= (r_rptr + AW'(1)) & MASK;
      r_count <= r_count + w_n_push - CW'(o_pop);
    end
  end
endmodule

// File: rtl/wb_stage_nway.sv
// rtl/wb_stage_nway.sv - N-lane writeback register with same-destination merge and serialised debug trace
module wb_stage_nway
  import wb_stage_nway_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int TRACE_DEPTH = 8,
  parameter int XLEN        = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    ws_allowin,
  input  logic                    ms_to_ws_valid,
  input  logic [LANES-1:0]        ms_lane_valid,
  input  logic [LANES-1:0]        ms_lane_we,
  input  logic [5*LANES-1:0]      ms_lane_dest,
  input  logic [XLEN*LANES-1:0]   ms_lane_wdata,
  input  logic [32*LANES-1:0]     ms_lane_pc,
  output logic [LANES-1:0]        rf_we,
  output logic [5*LANES-1:0]      rf_waddr,
  output logic [XLEN*LANES-1:0]   rf_wdata,
  output logic [LANES-1:0]        fwd_valid,
  output logic [5*LANES-1:0]      fwd_dest,
  output logic [XLEN*LANES-1:0]   fwd_wdata,
  output logic [31:0]             debug_wb_pc,
  output logic [3:0]              debug_wb_rf_wen,
  output logic [4:0]              debug_wb_rf_wnum,
  output logic [31:0]             debug_wb_rf_wdata
);
  localparam int REC_W = trace_rec_w(XLEN);
  localparam int CW    = $clog2(TRACE_DEPTH + 1);

  logic                       r_ws_valid;
  logic [LANES-1:0]           r_lane_valid;
  logic [LANES-1:0]           r_lane_we;
  logic [REG_W*LANES-1:0]     r_lane_dest;
  logic [XLEN*LANES-1:0]      r_lane_wdata;
  logic [PC_W*LANES-1:0]      r_lane_pc;

  logic [LANES-1:0]           w_lane_write;
  logic [LANES-1:0]           w_survive;
  logic [CW-1:0]              w_n_wr;
  logic [CW-1:0]              w_count;
  logic                       w_ready_go;
  logic                       w_retire;
  logic [REC_W*LANES-1:0]     w_push_data;
  logic                       w_pop;
  logic [REC_W-1:0]           w_head;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ws_valid <= 1'b0;
    end else if (ws_allowin) begin
      r_ws_valid <= ms_to_ws_valid;
    end
    if (!reset && ms_to_ws_valid && ws_allowin) begin
      r_lane_valid <= ms_lane_valid;
      r_lane_we    <= ms_lane_we;
      r_lane_dest  <= ms_lane_dest;
      r_lane_wdata <= ms_lane_wdata;
      r_lane_pc    <= ms_lane_pc;
    end
  end

  always_comb begin
    w_n_wr = '0;
    for (int i = 0; i < LANES; i++) begin
      w_lane_write[i] = r_ws_valid & r_lane_valid[i] & r_lane_we[i] &
                        (r_lane_dest[i*REG_W +: REG_W] != '0);
      w_n_wr = w_n_wr + CW'(w_lane_write[i]);
    end
  end

  // A younger lane writing the same register shadows every older one.
  always_comb begin
    w_survive = w_lane_write;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (w_lane_write[j] && (r_lane_dest[j*REG_W +: REG_W] == r_lane_dest[i*REG_W +: REG_W]))
          w_survive[i] = 1'b0;
      end
    end
  end

  assign w_ready_go = (CW'(TRACE_DEPTH) - w_count) >= w_n_wr;
  assign w_retire   = r_ws_valid & w_ready_go;
  assign ws_allowin = !r_ws_valid | w_ready_go;

  assign rf_we     = w_survive & {LANES{w_ready_go}};
  assign rf_waddr  = r_lane_dest;
  assign rf_wdata  = r_lane_wdata;
  assign fwd_valid = w_survive;
  assign fwd_dest  = r_lane_dest;
  assign fwd_wdata = r_lane_wdata;

  always_comb begin
    w_push_data = '0;
    for (int i = 0; i < LANES; i++) begin
      w_push_data[i*REC_W +: REC_W] = {r_lane_pc[i*PC_W +: PC_W],
                                       r_lane_dest[i*REG_W +: REG_W],
                                       r_lane_wdata[i*XLEN +: XLEN]};
    end
  end

  wb_trace_fifo #(
    .LANES (LANES),
    .DEPTH (TRACE_DEPTH),
    .W     (REC_W)
  ) u_trace_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_lane_write & {LANES{w_retire}}),
    .i_push_data (w_push_data),
    .o_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      debug_wb_pc       <= '0;
      debug_wb_rf_wen   <= '0;
      debug_wb_rf_wnum  <= '0;
      debug_wb_rf_wdata <= '0;
    end else if (w_pop) begin
      debug_wb_pc       <= w_head[XLEN+REG_W +: PC_W];
      debug_wb_rf_wen   <= WEN_ON;
      debug_wb_rf_wnum  <= w_head[XLEN +: REG_W];
      debug_wb_rf_wdata <= 32'(w_head[XLEN-1:0]);
    end else begin
      debug_wb_rf_wen   <= '0;
    end
  end
endmodule

// File: tb/tb_wb_stage_nway.sv
// tb/tb_wb_stage_nway.sv - self-checking bench for wb_stage_nway against a queue-based program-order model
module tb_wb_stage_nway;
  localparam int L = 2;
  localparam int D = 4;
  localparam int X = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            ms_to_ws_valid;
  logic [L-1:0]    ms_lane_valid, ms_lane_we;
  logic [5*L-1:0]  ms_lane_dest;
  logic [X*L-1:0]  ms_lane_wdata;
  logic [32*L-1:0] ms_lane_pc;
  logic            ws_allowin;
  logic [L-1:0]    rf_we, fwd_valid;
  logic [5*L-1:0]  rf_waddr, fwd_dest;
  logic [X*L-1:0]  rf_wdata, fwd_wdata;
  logic [31:0]     debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]      debug_wb_rf_wen;
  logic [4:0]      debug_wb_rf_wnum;

  wb_stage_nway #(.LANES(L), .TRACE_DEPTH(D), .XLEN(X)) dut (
    .clk(clk), .reset(reset), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_lane_valid(ms_lane_valid), .ms_lane_we(ms_lane_we),
    .ms_lane_dest(ms_lane_dest), .ms_lane_wdata(ms_lane_wdata), .ms_lane_pc(ms_lane_pc),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_wdata(fwd_wdata),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  typedef struct { logic [31:0] pc; logic [4:0] wnum; logic [31:0] wdata; } rec_t;
  typedef struct {
    logic [1:0] lv, we; logic [4:0] d0, d1; logic [31:0] w0, w1, p0, p1;
    logic [1:0] exp_we, exp_fwd; int n_rec;
  } vec_t;

  rec_t        m_q[$];
  bit          m_valid;
  logic [1:0]  m_lv, m_we;
  logic [4:0]  m_dest [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_pc [2];
  rec_t        m_dbg;
  logic [3:0]  m_wen;

  int n_pass = 0, n_tot = 0;
  bit chk_en = 0;
  logic [31:0] shadow_rf [32];
  logic [1:0] s_rf_we, s_fwd;
  bit s_retire, s_acc;
  int trace_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_group(input logic v, input logic [1:0] lv, input logic [1:0] we,
                           input logic [4:0] d0, input logic [4:0] d1,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] p0, input logic [31:0] p1);
    ms_to_ws_valid = v; ms_lane_valid = lv; ms_lane_we = we;
    ms_lane_dest = {d1, d0}; ms_lane_wdata = {w1, w0}; ms_lane_pc = {p1, p0};
  endtask

  task automatic idle();
    set_group(0, 2'b00, 2'b00, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // One clock: compare the DUT against the model, then advance the model by the same edge.
  task automatic step();
    logic [1:0] lw, surv;
    int nw;
    bit rdy;
    @(negedge clk);
    nw = 0;
    for (int i = 0; i < 2; i++) begin
      lw[i] = m_valid && m_lv[i] && m_we[i] && (m_dest[i] != 0);
      if (lw[i]) nw++;
    end
    surv = lw;
    if (lw[1] && m_dest[1] == m_dest[0]) surv[0] = 1'b0;
    rdy = (D - m_q.size()) >= nw;
    if (chk_en) begin
      chk("rf_we", rf_we, surv & {2{rdy}});
      chk("fwd_valid", fwd_valid, surv);
      chk("ws_allowin", ws_allowin, !m_valid || rdy);
      chk("dbg_wen", debug_wb_rf_wen, m_wen);
      chk("dbg_pc", debug_wb_pc, m_dbg.pc);
      chk("dbg_wnum", debug_wb_rf_wnum, m_dbg.wnum);
      chk("dbg_wdata", debug_wb_rf_wdata, m_dbg.wdata);
      for (int i = 0; i < 2; i++) begin
        if (surv[i]) begin
          chk("rf_waddr", rf_waddr[5*i +: 5], m_dest[i]);
          chk("rf_wdata", rf_wdata[32*i +: 32], m_wdata[i]);
        end
      end
    end
    s_rf_we = rf_we; s_fwd = fwd_valid;
    s_retire = (rf_we != 0);
    s_acc = ws_allowin && ms_to_ws_valid;
    if (debug_wb_rf_wen == 4'hF) trace_seen++;
    for (int i = 0; i < 2; i++)
      if (rf_we[i] === 1'b1) shadow_rf[rf_waddr[5*i +: 5]] = rf_wdata[32*i +: 32];

    if (reset) begin
      m_q.delete(); m_valid = 0; m_wen = 4'h0;
      m_dbg = '{pc: 32'd0, wnum: 5'd0, wdata: 32'd0};
    end else begin
      if (m_q.size() != 0) begin m_dbg = m_q.pop_front(); m_wen = 4'hF; end
      else m_wen = 4'h0;
      if (m_valid && rdy)
        for (int i = 0; i < 2; i++)
          if (lw[i]) m_q.push_back('{pc: m_pc[i], wnum: m_dest[i], wdata: m_wdata[i]});
      if (!m_valid || rdy) begin
        m_valid = ms_to_ws_valid;
        if (ms_to_ws_valid) begin
          m_lv = ms_lane_valid; m_we = ms_lane_we;
          for (int i = 0; i < 2; i++) begin
            m_dest[i] = ms_lane_dest[5*i +: 5];
            m_wdata[i] = ms_lane_wdata[32*i +: 32];
            m_pc[i] = ms_lane_pc[32*i +: 32];
          end
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic bp_group(input int g);
    set_group(1, 2'b11, 2'b11, 5'(2*g + 1), 5'(2*g + 2), 32'h100 + 32'(g), 32'h200 + 32'(g),
              32'hBFC0_1000 + 32'(8*g), 32'hBFC0_1004 + 32'(8*g));
  endtask

  vec_t tv [7];
  int ret_at[$];

  initial begin
    tv[0] = '{2'b11, 2'b11, 5'd3, 5'd5, 32'h11, 32'h22, 32'hBFC00000, 32'hBFC00004, 2'b11, 2'b11, 2};
    tv[1] = '{2'b11, 2'b11, 5'd7, 5'd7, 32'hA, 32'hB, 32'hBFC00008, 32'hBFC0000C, 2'b10, 2'b10, 2};
    tv[2] = '{2'b01, 2'b01, 5'd0, 5'd4, 32'h33, 32'h44, 32'hBFC00010, 32'hBFC00014, 2'b00, 2'b00, 0};
    tv[3] = '{2'b01, 2'b11, 5'd2, 5'd9, 32'h5, 32'h6, 32'hBFC00018, 32'hBFC0001C, 2'b01, 2'b01, 1};
    tv[4] = '{2'b11, 2'b11, 5'd0, 5'd0, 32'h7, 32'h8, 32'hBFC00020, 32'hBFC00024, 2'b00, 2'b00, 0};
    tv[5] = '{2'b11, 2'b10, 5'd4, 5'd4, 32'h9, 32'hC, 32'hBFC00028, 32'hBFC0002C, 2'b10, 2'b10, 1};
    tv[6] = '{2'b11, 2'b11, 5'd1, 5'd0, 32'hD, 32'hE, 32'hBFC00030, 32'hBFC00034, 2'b01, 2'b01, 1};

    for (int r = 0; r < 32; r++) shadow_rf[r] = 32'd0;
    reset = 1'b1; idle();
    step(); step();
    reset = 1'b0;
    chk("reset_allowin", ws_allowin, 1'b1);
    chk("reset_wen", debug_wb_rf_wen, 4'h0);
    chk("reset_pc", debug_wb_pc, 32'h0);
    chk("reset_rf_we", rf_we, 2'b00);
    chk("reset_fwd", fwd_valid, 2'b00);
    chk_en = 1;

    for (int k = 0; k < 7; k++) begin
      set_group(1, tv[k].lv, tv[k].we, tv[k].d0, tv[k].d1, tv[k].w0, tv[k].w1, tv[k].p0, tv[k].p1);
      step();
      idle();
      trace_seen = 0;
      step();
      chk("tv_rf_we", s_rf_we, tv[k].exp_we);
      chk("tv_fwd", s_fwd, tv[k].exp_fwd);
      for (int c = 0; c < 5; c++) step();
      chk("tv_nrec", trace_seen, tv[k].n_rec);
      if (k == 1) chk("r7_value", shadow_rf[7], 32'hB);
    end

    // Back-to-back double-write groups into a 4-deep queue.
    begin
      int g = 0;
      int cyc = 0;
      trace_seen = 0;
      bp_group(0);
      while (ret_at.size() < 6 && cyc < 40) begin
        step();
        if (s_retire) ret_at.push_back(cyc);
        if (s_acc) begin
          g++;
          if (g < 6) bp_group(g); else idle();
        end
        cyc++;
      end
      idle();
      chk("bp_retired", ret_at.size(), 6);
      if (ret_at.size() == 6) begin
        chk("bp_gap1", ret_at[1] - ret_at[0], 1);
        for (int i = 2; i < 6; i++) chk("bp_gap", ret_at[i] - ret_at[i-1], 2);
      end
      for (int c = 0; c < 12; c++) step();
      chk("bp_nrec", trace_seen, 12);
    end

    // Reset with three records queued and a group stalled in the stage.
    bp_group(0); step();
    bp_group(1); step();
    bp_group(2); step();
    bp_group(3);
    chk("pre_reset_stall", ws_allowin, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0; idle();
    chk("rst_wen", debug_wb_rf_wen, 4'h0);
    chk("rst_pc", debug_wb_pc, 32'h0);
    chk("rst_wnum", debug_wb_rf_wnum, 5'h0);
    chk("rst_wdata", debug_wb_rf_wdata, 32'h0);
    chk("rst_allowin", ws_allowin, 1'b1);
    chk("rst_rf_we", rf_we, 2'b00);
    trace_seen = 0;
    for (int c = 0; c < 6; c++) step();
    chk("rst_nrec", trace_seen, 0);

    for (int c = 0; c < 400; c++) begin
      set_group(($urandom % 4) != 0, 2'($urandom), 2'($urandom),
                5'($urandom % 4), 5'($urandom % 4), $urandom, $urandom, $urandom, $urandom);
      step();
    end
    idle();
    for (int c = 0; c < 12; c++) step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
